// File: rtl/traffic_pkg.sv
// Shared state encoding and default phase durations for the intersection scheduler.
package traffic_pkg;

    // Phase encoding; the numeric values are visible on the debug phase output.
    typedef enum logic [2:0] {
        S_MAIN_G  = 3'd0,
        S_MAIN_Y  = 3'd1,
        S_ALL_RED = 3'd2,
        S_SIDE_G  = 3'd3,
        S_SIDE_Y  = 3'd4,
        S_WALK    = 3'd5,
        S_EMERG   = 3'd6
    } phase_e;

    // Default durations, all in ticks.
    localparam int DEF_MIN_GREEN = 5;
    localparam int DEF_MAX_GREEN = 20;
    localparam int DEF_YELLOW    = 3;
    localparam int DEF_ALL_RED   = 1;
    localparam int DEF_WALK      = 6;
    localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase. Cleared on every phase entry and
// saturating, so a long main-green rest can never wrap back below MIN_GREEN.
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear has priority, otherwise advance on tick until full.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian walk, round-robin
// service between side road and pedestrians, and an emergency all-red hold.
// Lamps are a Moore decode of the registered phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW    = DEF_YELLOW,
    parameter int ALL_RED   = DEF_ALL_RED,
    parameter int WALK      = DEF_WALK,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_side,
    input  logic       req_ped,
    input  logic       emergency,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic       walk,
    output logic [2:0] phase
);

    // Last timer value of each timed phase (the tick on which it ends).
    localparam logic [CNT_W-1:0] MIN_END = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_END = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_END = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_END  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WLK_END = CNT_W'(WALK - 1);

    phase_e           state_q, state_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             last_ped_q, last_ped_d;
    logic             from_main_q, from_main_d;
    logic             enter_side, enter_walk;
    logic             timer_clr;
    logic [CNT_W-1:0] count;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .tick  (tick),
        .count (count)
    );

    // Any phase change restarts the timer; the entering tick belongs to the old phase.
    assign timer_clr = (state_d != state_q);

    // Next-phase selection and the all-red arbitration between side and walk.
    always_comb begin
        state_d     = state_q;
        from_main_d = from_main_q;
        unique case (state_q)
            S_MAIN_G: begin
                if (emergency) begin
                    state_d = S_MAIN_Y;
                end else if (tick && (count >= MIN_END) && (side_pend_q || ped_pend_q)) begin
                    state_d = S_MAIN_Y;
                end
            end
            S_MAIN_Y: begin
                if (tick && (count == YEL_END)) begin
                    state_d     = S_ALL_RED;
                    from_main_d = 1'b1;
                end
            end
            S_ALL_RED: begin
                if (tick && (count == AR_END)) begin
                    if (emergency) begin
                        state_d = S_EMERG;
                    end else if (from_main_q) begin
                        if (side_pend_q && ped_pend_q) state_d = last_ped_q ? S_SIDE_G : S_WALK;
                        else if (side_pend_q)          state_d = S_SIDE_G;
                        else if (ped_pend_q)           state_d = S_WALK;
                        else                           state_d = S_MAIN_G;
                    end else begin
                        state_d = S_MAIN_G;
                    end
                end
            end
            S_SIDE_G: begin
                if (emergency) begin
                    state_d = S_SIDE_Y;
                end else if (tick && (((count >= MIN_END) && !req_side) || (count == MAX_END))) begin
                    state_d = S_SIDE_Y;
                end
            end
            S_SIDE_Y: begin
                if (tick && (count == YEL_END)) begin
                    state_d     = S_ALL_RED;
                    from_main_d = 1'b0;
                end
            end
            S_WALK: begin
                if (emergency || (tick && (count == WLK_END))) begin
                    state_d     = S_ALL_RED;
                    from_main_d = 1'b0;
                end
            end
            S_EMERG: begin
                if (tick && !emergency) begin
                    state_d     = S_ALL_RED;
                    from_main_d = 1'b0;
                end
            end
            default: state_d = S_MAIN_G;
        endcase
    end

    // Request latches and round-robin memory; a clear on service entry beats a new request.
    always_comb begin
        enter_side  = (state_d == S_SIDE_G) && (state_q != S_SIDE_G);
        enter_walk  = (state_d == S_WALK) && (state_q != S_WALK);
        side_pend_d = enter_side ? 1'b0 : (side_pend_q | req_side);
        ped_pend_d  = enter_walk ? 1'b0 : (ped_pend_q | req_ped);
        last_ped_d  = last_ped_q;
        if (enter_side) last_ped_d = 1'b0;
        if (enter_walk) last_ped_d = 1'b1;
    end

    // Phase and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_MAIN_G;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            last_ped_q  <= 1'b0;
            from_main_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            last_ped_q  <= last_ped_d;
            from_main_q <= from_main_d;
        end
    end

    // Lamp decode: one lamp per head in every phase, red unless the phase says otherwise.
    always_comb begin
        main_r = 1'b1; main_y = 1'b0; main_g = 1'b0;
        side_r = 1'b1; side_y = 1'b0; side_g = 1'b0;
        walk   = 1'b0;
        unique case (state_q)
            S_MAIN_G: begin main_r = 1'b0; main_g = 1'b1; end
            S_MAIN_Y: begin main_r = 1'b0; main_y = 1'b1; end
            S_SIDE_G: begin side_r = 1'b0; side_g = 1'b1; end
            S_SIDE_Y: begin side_r = 1'b0; side_y = 1'b1; end
            S_WALK:   walk = 1'b1;
            default:  ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// checked every cycle against a tick-counting reference of the phase rules.
module tb_traffic_phase_scheduler;

    localparam int P_MAIN_G = 0, P_MAIN_Y = 1, P_ALL_RED = 2, P_SIDE_G = 3;
    localparam int P_SIDE_Y = 4, P_WALK = 5, P_EMERG = 6;
    localparam int D_MIN = 5, D_MAX = 20, D_YEL = 3, D_AR = 1, D_WALK = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic req_side = 1'b0;
    logic req_ped = 1'b0;
    logic emergency = 1'b0;
    logic main_r, main_y, main_g, side_r, side_y, side_g, walk;
    logic [2:0] phase;

    int vectors = 0;
    int miscompares = 0;
    int tick_cnt = 0;
    logic [9:0] exp_q[$];
    bit started = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .req_side  (req_side),
        .req_ped   (req_ped),
        .emergency (emergency),
        .main_r    (main_r),
        .main_y    (main_y),
        .main_g    (main_g),
        .side_r    (side_r),
        .side_y    (side_y),
        .side_g    (side_g),
        .walk      (walk),
        .phase     (phase)
    );

    // {main_r,main_y,main_g, side_r,side_y,side_g, walk} for each phase.
    function automatic logic [6:0] lamps(input int ph);
        case (ph)
            P_MAIN_G: return 7'b001_100_0;
            P_MAIN_Y: return 7'b010_100_0;
            P_SIDE_G: return 7'b100_001_0;
            P_SIDE_Y: return 7'b100_010_0;
            P_WALK:   return 7'b100_100_1;
            default:  return 7'b100_100_0;
        endcase
    endfunction

    // Fixed length of the timed phases (0 = not a fixed-length phase).
    function automatic int dur(input int ph);
        case (ph)
            P_MAIN_Y:  return D_YEL;
            P_ALL_RED: return D_AR;
            P_WALK:    return D_WALK;
            P_SIDE_Y:  return D_YEL;
            default:   return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    int m_ph = P_MAIN_G;
    int m_el = 0;          // ticks fully spent in the current phase
    bit m_sp = 0, m_pp = 0, m_lp = 0, m_fm = 0;

    always @(posedge clk) begin : model
        int  nxt;
        bit  fm_n;
        bit  last_tick;    // this tick would complete the phase's fixed length
        logic [2:0] ph3;
        if (reset) begin
            m_ph = P_MAIN_G; m_el = 0;
            m_sp = 0; m_pp = 0; m_lp = 0; m_fm = 0;
        end else begin
            nxt = m_ph;
            fm_n = m_fm;
            last_tick = tick && (dur(m_ph) != 0) && (m_el + 1 == dur(m_ph));
            case (m_ph)
                P_MAIN_G:
                    if (emergency || (tick && m_el + 1 >= D_MIN && (m_sp || m_pp))) nxt = P_MAIN_Y;
                P_MAIN_Y:
                    if (last_tick) begin nxt = P_ALL_RED; fm_n = 1; end
                P_ALL_RED:
                    if (last_tick) begin
                        if (emergency)         nxt = P_EMERG;
                        else if (!m_fm)        nxt = P_MAIN_G;
                        else if (m_sp && m_pp) nxt = m_lp ? P_SIDE_G : P_WALK;
                        else if (m_sp)         nxt = P_SIDE_G;
                        else if (m_pp)         nxt = P_WALK;
                        else                   nxt = P_MAIN_G;
                    end
                P_SIDE_G:
                    if (emergency || (tick && ((m_el + 1 >= D_MIN && !req_side) || m_el + 1 == D_MAX)))
                        nxt = P_SIDE_Y;
                P_SIDE_Y:
                    if (last_tick) begin nxt = P_ALL_RED; fm_n = 0; end
                P_WALK:
                    if (emergency || last_tick) begin nxt = P_ALL_RED; fm_n = 0; end
                P_EMERG:
                    if (tick && !emergency) begin nxt = P_ALL_RED; fm_n = 0; end
                default: nxt = P_MAIN_G;
            endcase
            m_sp = m_sp | req_side;
            m_pp = m_pp | req_ped;
            if (nxt != m_ph) begin
                if (nxt == P_SIDE_G) begin m_sp = 0; m_lp = 0; end
                if (nxt == P_WALK)   begin m_pp = 0; m_lp = 1; end
                m_el = 0;
            end else if (tick) begin
                m_el = m_el + 1;
            end
            m_ph = nxt;
            m_fm = fm_n;
        end
        ph3 = 3'(m_ph);
        exp_q.push_back({ph3, lamps(m_ph)});
        started = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [9:0] act;
        logic [9:0] exp_v;
        if (started) begin
            act = {phase, main_r, main_y, main_g, side_r, side_y, side_g, walk};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL no_expectation t=%0t got phase=%0d lamps=%b", $time, act[9:7], act[6:0]);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    miscompares++;
                    $display("FAIL phase_lamps t=%0t got phase=%0d lamps=%b want phase=%0d lamps=%b",
                             $time, act[9:7], act[6:0], exp_v[9:7], exp_v[6:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance n clocks; tick is a one-clock strobe every fourth clock.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick_cnt++;
            tick = (tick_cnt % 4 == 0);
        end
    endtask

    task automatic pulse_req(input bit s, input bit p);
        req_side = s;
        req_ped  = p;
        run(1);
        req_side = 1'b0;
        req_ped  = 1'b0;
    endtask

    // Wait until the reference reaches a phase; an expired budget is a failure.
    task automatic wait_model(input int ph, input int budget);
        int k;
        k = 0;
        while (m_ph != ph && k < budget) begin
            run(1);
            k++;
        end
        if (m_ph != ph) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase got phase=%0d want phase=%0d within %0d clks", m_ph, ph, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        run(3);
        reset = 1'b0;

        // Idle: main rests green for 50 ticks.
        run(200);

        // Single side request.
        run(8);
        pulse_req(1, 0);
        run(150);

        // Side held: side green runs to its maximum.
        req_side = 1'b1;
        run(200);
        req_side = 1'b0;
        run(150);

        // Side and pedestrian together: walk first, then side after a main green.
        pulse_req(1, 1);
        run(250);

        // Emergency raised during side green, later dropped.
        pulse_req(1, 0);
        wait_model(P_SIDE_G, 200);
        run(9);
        emergency = 1'b1;
        run(60);
        emergency = 1'b0;
        run(60);

        // Reset in the middle of walk with both requests latched.
        pulse_req(0, 1);
        wait_model(P_WALK, 200);
        pulse_req(1, 1);
        run(5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(100);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) req_side = ~req_side;
            req_ped = ($urandom_range(0, 59) == 0);
            if (emergency) begin
                if ($urandom_range(0, 59) == 0) emergency = 1'b0;
            end else begin
                if ($urandom_range(0, 499) == 0) emergency = 1'b1;
            end
            reset = ($urandom_range(0, 1499) == 0);
            run(1);
        end
        reset = 1'b0;
        emergency = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Timed phase scheduler for a two-road intersection (main road, side road) with a pedestrian crossing.
- Sequences the main and side signal heads and the walk lamp using tick-based timers.
- Latches side-road and pedestrian service requests and arbitrates between them round-robin.
- Provides an emergency all-red override.
- Sits above the light-output decode; consumes a 1 Hz `tick` enable from the clock-divider block.

Parameters:
- MIN_GREEN, 5, minimum green duration in ticks (main and side).
- MAX_GREEN, 20, maximum side-green duration in ticks while side vehicle presence is held.
- YELLOW, 3, yellow duration in ticks.
- ALL_RED, 1, all-red clearance duration in ticks.
- WALK, 6, pedestrian walk duration in ticks.
- CNT_W, 5, timer width; must satisfy 2^CNT_W > max(all durations).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide timing enable (1 Hz strobe)
- req_side  in  1  side-road vehicle sensor (level; presence while high)
- req_ped  in  1  pedestrian button (pulse or level)
- emergency  in  1  emergency override request (level)
- main_r, main_y, main_g  out  1 each  main-road lamps
- side_r, side_y, side_g  out  1 each  side-road lamps
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding, for debug/status

Behaviour:
- Reset is synchronous on clk, active-high. On reset:
  - state=MAIN_G, timer=0, side_pend=0, ped_pend=0, last_ped=0, from_main=0.
  - Outputs: main_g=1, side_r=1, all other lamps 0, phase=MAIN_G.
  - A reset mid-operation of any state takes effect at the next edge.
- Outputs are a Moore decode of the registered state (no input-to-output paths). Lamps change on the clock edge that changes state.
- Lamp decode per state (main/side/walk):
  - MAIN_G: G / R / 0
  - MAIN_Y: Y / R / 0
  - ALL_RED: R / R / 0
  - SIDE_G: R / G / 0
  - SIDE_Y: R / Y / 0
  - WALK: R / R / 1
  - EMERG: R / R / 0
- Exactly one lamp per head is lit in every state.
- Timer:
  - Cleared on every state entry.
  - On tick, increments unless the state ends on that tick.
  - "Done(D)" = tick && timer==D-1, so a timed state lasts exactly D ticks.
- Request latches:
  - side_pend is set when req_side=1; cleared on the edge entering SIDE_G.
  - ped_pend is set when req_ped=1; cleared on the edge entering WALK.
  - If set and clear coincide, clear wins.
- Transitions, evaluated every clk:
  - MAIN_G:
    - emergency=1 -> MAIN_Y at next edge, regardless of tick or timer.
    - Else, on tick with timer>=MIN_GREEN-1 and (side_pend|ped_pend) -> MAIN_Y.
    - Otherwise stay. Main rests green indefinitely when there are no requests.
  - MAIN_Y: Done(YELLOW) -> ALL_RED, with from_main=1.
  - SIDE_G:
    - emergency=1 -> SIDE_Y.
    - Else, on tick with (timer>=MIN_GREEN-1 && req_side==0) or timer==MAX_GREEN-1 -> SIDE_Y.
  - SIDE_Y: Done(YELLOW) -> ALL_RED, with from_main=0.
  - WALK:
    - emergency=1 -> ALL_RED at next edge, with from_main=0.
    - Else Done(WALK) -> ALL_RED, with from_main=0.
  - ALL_RED, on Done(ALL_RED):
    - If emergency=1 -> EMERG.
    - Else if from_main=1: both pending -> SIDE_G if last_ped=1, else WALK. Only side_pend -> SIDE_G. Only ped_pend -> WALK. Neither -> MAIN_G.
    - Else -> MAIN_G.
    - Entering SIDE_G sets last_ped=0; entering WALK sets last_ped=1.
  - EMERG: hold while emergency=1. On the first tick with emergency=0 -> ALL_RED, with from_main=0.
- Simultaneous events:
  - Emergency has priority over any tick-driven exit in the same cycle.
  - A tick coinciding with a state entry is consumed by the old state.
- No green is ever entered without passing through ALL_RED.
- Green is never adjacent to green.

Decomposition:
- Package traffic_pkg:
  - 3-bit state localparams: MAIN_G=0, MAIN_Y=1, ALL_RED=2, SIDE_G=3, SIDE_Y=4, WALK=5, EMERG=6.
  - Default duration constants.
- One sub-module, phase_timer (CNT_W wide):
  - Inputs: clk, reset, clr, tick.
  - Outputs: count.
  - The scheduler compares count against durations itself.

Test Plan:
- Tick every 4 clks, no requests for 50 ticks -> main_g=1, side_r=1 throughout; phase=0.
- Single req_side pulse at tick 2 -> MAIN_G ends at tick 5; then MAIN_Y for 3 ticks, ALL_RED 1, SIDE_G 5, SIDE_Y 3, ALL_RED 1, then MAIN_G. side_pend=0 after SIDE_G entry.
- req_side held high from tick 0 -> SIDE_G lasts exactly 20 ticks, then SIDE_Y.
- req_ped and req_side pulsed in the same clk, last_ped=0 -> WALK=1 for 6 ticks, ALL_RED, MAIN_G for 5 ticks, MAIN_Y, ALL_RED, then SIDE_G. last_ped toggles 1 then 0.
- emergency raised at SIDE_G tick 2 between ticks -> SIDE_Y on the next clk, 3 ticks, ALL_RED, then EMERG (all red). Drop emergency -> next tick ALL_RED, next tick MAIN_G.
- Reset pulsed mid-WALK with ped_pend and side_pend set -> next edge MAIN_G, walk=0, both pends=0, timer=0.
